// File: rtl/efx_fifo_fwft_rd_ctl_pkg.sv
// ---------------------------------------------------------------------------
// efx_fifo_fwft_rd_ctl_pkg
//   Shared definitions for the FWFT read-side controller:
//     buf_state_t  - output buffer occupancy states (2-bit encodings, value ==
//                    number of words held)
//     depth2width  - address width needed for a given FIFO depth
//     bin2gray     - binary to reflected Gray conversion (32-bit, callers cast)
// ---------------------------------------------------------------------------
package efx_fifo_fwft_rd_ctl_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  function automatic int unsigned depth2width(input int unsigned depth);
    return (depth <= 32'd2) ? 32'd1 : 32'($clog2(depth));
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/efx_fifo_fwft_rd_ctl_skid2.sv
// ---------------------------------------------------------------------------
// efx_fifo_skid2
//   Two-entry head/skid register pair with occupancy FSM. The head register
//   is the word presented to the user; the skid register absorbs one RAM
//   return that arrives while the head is still held.
// Ports
//   clk_i       in   clock
//   a_rst_n_i   in   asynchronous reset, active low
//   ret_i       in   RAM read data returning this cycle
//   ret_data_i  in   returning RAM word
//   pop_i       in   head consumed this cycle (only meaningful when valid_o)
//   head_o      out  head word, registered
//   valid_o     out  head word valid
//   occ_o       out  words held: 0, 1 or 2
// ---------------------------------------------------------------------------
module efx_fifo_skid2
  import efx_fifo_fwft_rd_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  ret_i,
  input  logic [DATA_WIDTH-1:0] ret_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic [1:0]            occ_o
);

  buf_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (ret_i) begin
          head_d  = ret_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (ret_i && !pop_i) begin
          skid_d  = ret_data_i;
          state_d = BUF_TWO;
        end else if (ret_i && pop_i) begin
          head_d  = ret_data_i;
        end else if (pop_i) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // A return without a pop cannot happen here: the issue rule never
        // launches a read that would overflow the pair.
        if (pop_i) begin
          head_d = skid_q;
          if (ret_i) begin
            skid_d = ret_data_i;
          end else begin
            state_d = BUF_ONE;
          end
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (state_q != BUF_EMPTY);
  assign occ_o   = state_q;

  no_overflow_a : assert property (@(posedge clk_i) disable iff (!a_rst_n_i)
                                   !(state_q == BUF_TWO && ret_i && !pop_i))
    else $error("efx_fifo_skid2: RAM return into a full buffer");

endmodule

// File: rtl/efx_fifo_fwft_rd_ctl.sv
// ---------------------------------------------------------------------------
// efx_fifo_fwft_rd_ctl
//   Read-side controller for the FIFO RAM. Issues RAM reads from the empty
//   flag, prefetches into a 2-entry buffer and presents first-word-fall-
//   through data with a valid/pop handshake at one word per cycle.
// Ports
//   clk_i           in   read clock
//   a_rst_n_i       in   asynchronous reset, active low
//   empty_i         in   FIFO empty flag, same clock
//   ram_rdata_i     in   RAM read data, valid one cycle after rd_ram_o
//   rd_en_i         in   user pop, effective only while rd_valid_o
//   rd_ram_o        out  RAM read enable
//   rd_adr_o        out  RAM read address, binary, registered
//   rd_adr_gray_o   out  Gray copy of rd_adr_o (0 when SYNC_CLK=1)
//   rd_data_o       out  head word, registered
//   rd_valid_o      out  head word valid
//   underflow_o     out  one-cycle pulse for rd_en_i while not valid
//   prefetch_cnt_o  out  words held in the output buffer
// ---------------------------------------------------------------------------
module efx_fifo_fwft_rd_ctl
  import efx_fifo_fwft_rd_ctl_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = int'(depth2width(DEPTH)),
  parameter int DATA_WIDTH = 32,
  parameter int SYNC_CLK   = 1
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  rd_en_i,
  output logic                  rd_ram_o,
  output logic [ADDR_WIDTH-1:0] rd_adr_o,
  output logic [ADDR_WIDTH-1:0] rd_adr_gray_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  underflow_o,
  output logic [1:0]            prefetch_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADR   = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    WRAP_EARLY = (DEPTH != (2 ** ADDR_WIDTH));

  logic                  inflight_q;
  logic                  underflow_q;
  logic [ADDR_WIDTH-1:0] rd_adr_q, rd_adr_d;
  logic                  pop;
  logic                  issue;
  logic                  valid;
  logic [1:0]            occ;

  assign pop = rd_en_i & valid;

  // Keep buffered plus in-flight words at most two, unless a pop frees a
  // slot this same cycle. Gated by reset so no read is issued while held.
  assign issue = a_rst_n_i & ~empty_i &
                 ((({1'b0, occ} + {2'b00, inflight_q}) < 3'd2) | pop);

  always_comb begin
    rd_adr_d = rd_adr_q;
    if (issue) begin
      if (WRAP_EARLY && (rd_adr_q == LAST_ADR)) begin
        rd_adr_d = '0;
      end else begin
        rd_adr_d = rd_adr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      inflight_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_adr_q    <= '0;
    end else begin
      inflight_q  <= issue;
      underflow_q <= rd_en_i & ~valid;
      rd_adr_q    <= rd_adr_d;
    end
  end

  // Gray register is loaded from the next binary address so both outputs
  // change on the same edge.
  if (SYNC_CLK == 0) begin : g_gray
    logic [ADDR_WIDTH-1:0] rd_adr_gray_q;
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
        rd_adr_gray_q <= '0;
      end else begin
        rd_adr_gray_q <= ADDR_WIDTH'(bin2gray(32'(rd_adr_d)));
      end
    end
    assign rd_adr_gray_o = rd_adr_gray_q;
  end else begin : g_no_gray
    assign rd_adr_gray_o = '0;
  end

  efx_fifo_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid2 (
    .clk_i      (clk_i),
    .a_rst_n_i  (a_rst_n_i),
    .ret_i      (inflight_q),
    .ret_data_i (ram_rdata_i),
    .pop_i      (pop),
    .head_o     (rd_data_o),
    .valid_o    (valid),
    .occ_o      (occ)
  );

  assign rd_ram_o       = issue;
  assign rd_adr_o       = rd_adr_q;
  assign rd_valid_o     = valid;
  assign underflow_o    = underflow_q;
  assign prefetch_cnt_o = occ;

endmodule

// File: tb/tb_efx_fifo_fwft_rd_ctl.sv
// Bench for efx_fifo_fwft_rd_ctl with a small behavioural FIFO (RAM plus
// empty flag) standing in for the control state machine. Written words are
// pushed to a scoreboard; the monitor pops and compares on every user pop.
module tb_efx_fifo_fwft_rd_ctl;

  localparam int DEPTH = 5;
  localparam int DW    = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty_i;
  logic [DW-1:0] ram_rdata_i = '0;
  logic          rd_en_i = 1'b0;
  logic          rd_ram_o;
  logic [AW-1:0] rd_adr_o;
  logic [AW-1:0] rd_adr_gray_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          underflow_o;
  logic [1:0]    prefetch_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  int            wr_cnt = 0;
  int            wr_ptr = 0;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_ptr = '0;
  logic [DW-1:0] exp_q [$];

  efx_fifo_fwft_rd_ctl #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .SYNC_CLK   (0)
  ) dut (
    .clk_i          (clk),
    .a_rst_n_i      (rst_n),
    .empty_i        (empty_i),
    .ram_rdata_i    (ram_rdata_i),
    .rd_en_i        (rd_en_i),
    .rd_ram_o       (rd_ram_o),
    .rd_adr_o       (rd_adr_o),
    .rd_adr_gray_o  (rd_adr_gray_o),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .underflow_o    (underflow_o),
    .prefetch_cnt_o (prefetch_cnt_o)
  );

  always #5 clk = ~clk;

  // FIFO model: empty drops as soon as a word is written, rises on the edge
  // that consumes the last word.
  assign empty_i = (wr_cnt == rd_cnt);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= 0;
      rd_ptr <= '0;
    end else if (rd_ram_o) begin
      rd_cnt <= rd_cnt + 1;
      rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // RAM read data register, deliberately not reset.
  always @(posedge clk) begin
    if (rd_ram_o) ram_rdata_i <= mem[rd_ptr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_nostep(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = (wr_ptr == DEPTH - 1) ? 0 : wr_ptr + 1;
    wr_cnt      = wr_cnt + 1;
    exp_q.push_back(d);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    write_nostep(d);
    step();
  endtask

  // Monitor: address/Gray tracking every cycle, data on every pop.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("rd_adr", 32'(rd_adr_o), 32'(rd_ptr));
      chk("rd_adr_gray", 32'(rd_adr_gray_o), 32'(rd_ptr ^ (rd_ptr >> 1)));
      if (rd_en_i && rd_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no word at %0t", rd_data_o, $time);
        end else begin
          chk("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset held while the FIFO already holds words.
    step();
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    @(negedge clk);
    chk("rst_rd_ram", 32'(rd_ram_o), 0);
    chk("rst_rd_adr", 32'(rd_adr_o), 0);
    chk("rst_gray", 32'(rd_adr_gray_o), 0);
    chk("rst_rd_data", 32'(rd_data_o), 0);
    chk("rst_valid", 32'(rd_valid_o), 0);
    chk("rst_underflow", 32'(underflow_o), 0);
    chk("rst_prefetch", 32'(prefetch_cnt_o), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rd_ram", 32'(rd_ram_o), 1);
    chk("rel_valid_n0", 32'(rd_valid_o), 0);
    @(negedge clk);
    chk("rel_valid_n1", 32'(rd_valid_o), 0);
    @(negedge clk);
    chk("rel_valid_n2", 32'(rd_valid_o), 1);

    // Prefetch stops at two words with no pops.
    repeat (4) step();
    @(negedge clk);
    chk("prefetch_reads", 32'(rd_cnt), 2);
    chk("prefetch_cnt", 32'(prefetch_cnt_o), 2);
    chk("prefetch_head", 32'(rd_data_o), 32'h11);
    chk("prefetch_idle_rd_ram", 32'(rd_ram_o), 0);

    // Back-to-back pops of the three words.
    step();
    rd_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_valid", 32'(rd_valid_o), 1);
      step();
    end
    rd_en_i = 1'b0;
    @(negedge clk);
    chk("burst_end_valid", 32'(rd_valid_o), 0);
    chk("burst_drained", 32'(exp_q.size()), 0);

    // Pop request against an empty FIFO.
    step();
    rd_en_i = 1'b1;
    @(negedge clk);
    chk("uf_before", 32'(underflow_o), 0);
    chk("uf_valid0", 32'(rd_valid_o), 0);
    step();
    rd_en_i = 1'b0;
    @(negedge clk);
    chk("uf_pulse", 32'(underflow_o), 1);
    chk("uf_valid1", 32'(rd_valid_o), 0);
    chk("uf_adr_hold", 32'(rd_adr_o), 3);
    chk("uf_rd_ram", 32'(rd_ram_o), 0);
    step();
    @(negedge clk);
    chk("uf_after", 32'(underflow_o), 0);

    // Stream 12 words through the depth-5 FIFO with rd_en held high.
    step();
    rd_en_i = 1'b1;
    idx = 0;
    cyc = 0;
    while ((idx < 12 || exp_q.size() != 0) && cyc < 200) begin
      if (idx < 12 && (wr_cnt - rd_cnt) < DEPTH) begin
        write_word(DW'(8'hA0 + idx));
        idx++;
      end else begin
        step();
      end
      cyc++;
    end
    chk("stream_drained", 32'(exp_q.size()), 0);
    chk("stream_reads", 32'(rd_cnt), 15);
    rd_en_i = 1'b0;

    // Single word, popped on its first valid cycle.
    repeat (2) step();
    write_nostep(8'h5A);
    rd_en_i = 1'b1;
    @(negedge clk);
    chk("single_rd_ram", 32'(rd_ram_o), 1);
    step();
    @(negedge clk);
    chk("single_rd_ram_n1", 32'(rd_ram_o), 0);
    chk("single_valid_n1", 32'(rd_valid_o), 0);
    step();
    @(negedge clk);
    chk("single_valid_n2", 32'(rd_valid_o), 1);
    chk("single_rd_ram_n2", 32'(rd_ram_o), 0);
    step();
    rd_en_i = 1'b0;
    @(negedge clk);
    chk("single_valid_n3", 32'(rd_valid_o), 0);
    chk("single_rd_ram_n3", 32'(rd_ram_o), 0);
    chk("single_prefetch_n3", 32'(prefetch_cnt_o), 0);

    // Reset while buffered words and a read return are pending.
    step();
    write_word(8'hC1);
    write_word(8'hC2);
    write_word(8'hC3);
    write_word(8'hC4);
    repeat (3) step();
    @(negedge clk);
    chk("pre_rst_prefetch", 32'(prefetch_cnt_o), 2);
    chk("pre_rst_head", 32'(rd_data_o), 32'hC1);
    step();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_prefetch1", 32'(prefetch_cnt_o), 1);
    #1;
    rst_n  = 1'b0;
    wr_cnt = 0;
    wr_ptr = 0;
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(rd_valid_o), 0);
      chk("post_rst_prefetch", 32'(prefetch_cnt_o), 0);
      chk("post_rst_data", 32'(rd_data_o), 0);
      chk("post_rst_rd_ram", 32'(rd_ram_o), 0);
    end

    // Clean restart from address 0.
    step();
    write_word(8'h77);
    rd_en_i = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("restart_drained", 32'(exp_q.size()), 0);
    rd_en_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
